// File: rtl/cpu_timer_if.sv
// -----------------------------------------------------------------------------
// cpu_timer_if
//   CPU system-bus view of the DMG timer/divider block.
//
//   Signals
//     t_cycle       CPU T-cycle index inside the current M-cycle (0..3)
//     bus_addr      CPU mem_addr
//     bus_enable    CPU mem_enable
//     bus_write     CPU mem_write
//     bus_data_in   CPU mem_data_out (write data towards the timer)
//     bus_data_out  read data returned to the top-level bus read mux
//     bus_selected  address decode hit for the timer register window
//
//   Modports
//     master  CPU side: drives cycle index, address, strobes and write data
//     slave   timer side: returns read data and the decode flag
// -----------------------------------------------------------------------------
interface cpu_timer_if;
   logic [1:0]  t_cycle;
   logic [15:0] bus_addr;
   logic        bus_enable;
   logic        bus_write;
   logic [7:0]  bus_data_in;
   logic [7:0]  bus_data_out;
   logic        bus_selected;

   modport master (
      output t_cycle, bus_addr, bus_enable, bus_write, bus_data_in,
      input  bus_data_out, bus_selected
   );

   modport slave (
      input  t_cycle, bus_addr, bus_enable, bus_write, bus_data_in,
      output bus_data_out, bus_selected
   );
endinterface

// File: rtl/cpu_timer.sv
// -----------------------------------------------------------------------------
// cpu_timer
//   DMG timer/divider: DIV (BASE_ADDR), TIMA (+1), TMA (+2), TAC (+3).
//   A free-running 16-bit divider feeds a selectable tap; each falling edge
//   of the gated tap increments TIMA. A TIMA overflow reads as 00 for four
//   clocks, then TIMA is reloaded from TMA together with a one-clock
//   interrupt pulse, followed by a four-clock reload window.
//
//   Ports
//     clk        system clock (4 MHz)
//     reset      synchronous reset, active high
//     bus        cpu_timer_if.slave: t_cycle, address, strobes, write data
//                in; combinational read data and decode flag out
//     irq_timer  one-clock registered timer interrupt request
// -----------------------------------------------------------------------------
module cpu_timer #(
   parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
   input  logic       clk,
   input  logic       reset,
   cpu_timer_if.slave bus,
   output logic       irq_timer
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PENDING = 2'd1,
      S_RELOAD  = 2'd2
   } state_e;

   localparam logic [1:0] OFF_DIV  = 2'd0;
   localparam logic [1:0] OFF_TIMA = 2'd1;
   localparam logic [1:0] OFF_TMA  = 2'd2;
   localparam logic [1:0] OFF_TAC  = 2'd3;

   // Registered state
   logic [15:0] div_q,  div_d;
   logic [7:0]  tima_q, tima_d;
   logic [7:0]  tma_q,  tma_d;
   logic [2:0]  tac_q,  tac_d;
   logic        timer_signal_q;
   state_e      state_q, state_d;
   logic [1:0]  cnt_q,  cnt_d;
   logic        irq_q,  irq_d;

   // Decode and datapath
   logic [15:0] offset;
   logic [1:0]  reg_sel;
   logic        selected;
   logic        commit;
   logic        commit_div, commit_tima, commit_tma, commit_tac;
   logic        tap_bit;
   logic        timer_signal;
   logic        tick;
   logic [7:0]  reload_base;
   logic [7:0]  rd_data;

   // ---------------------------------------------------------------------------
   // Address decode. Subtracting the base lets a single compare on the upper
   // offset bits cover the four-register window.
   // ---------------------------------------------------------------------------
   assign offset   = bus.bus_addr - BASE_ADDR;
   assign reg_sel  = offset[1:0];
   assign selected = bus.bus_enable && (offset[15:2] == 14'd0);

   // Writes take effect only on the last T-cycle edge, so each CPU M-cycle
   // produces exactly one commit.
   assign commit      = selected && bus.bus_write && (bus.t_cycle == 2'd3);
   assign commit_div  = commit && (reg_sel == OFF_DIV);
   assign commit_tima = commit && (reg_sel == OFF_TIMA);
   assign commit_tma  = commit && (reg_sel == OFF_TMA);
   assign commit_tac  = commit && (reg_sel == OFF_TAC);

   // ---------------------------------------------------------------------------
   // Tap selection and falling-edge detect. Falls caused by a DIV reset, a TAC
   // disable or a tap change count as ticks, like any other fall.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written in always_comb is given a value on every
      // path (default first), otherwise synthesis infers a latch.
      tap_bit = 1'b0;
      case (tac_q[1:0])
         2'b00:   tap_bit = div_q[9];
         2'b01:   tap_bit = div_q[3];
         2'b10:   tap_bit = div_q[5];
         default: tap_bit = div_q[7];
      endcase
   end

   assign timer_signal = tac_q[2] & tap_bit;
   assign tick         = timer_signal_q & ~timer_signal;

   // ---------------------------------------------------------------------------
   // Read mux. The unused TAC bits read as ones.
   // ---------------------------------------------------------------------------
   always_comb begin
      rd_data = 8'hFF;
      if (selected) begin
         case (reg_sel)
            OFF_DIV:  rd_data = div_q[15:8];
            OFF_TIMA: rd_data = tima_q;
            OFF_TMA:  rd_data = tma_q;
            default:  rd_data = {5'b11111, tac_q};
         endcase
      end
   end

   assign bus.bus_data_out = rd_data;
   assign bus.bus_selected = selected;
   assign irq_timer        = irq_q;

   // ---------------------------------------------------------------------------
   // Next-state logic: register writes, TIMA counting and the overflow FSM.
   // ---------------------------------------------------------------------------
   always_comb begin
      div_d       = commit_div ? 16'h0000 : div_q + 16'd1;
      tima_d      = tima_q;
      tma_d       = commit_tma ? bus.bus_data_in : tma_q;
      tac_d       = commit_tac ? bus.bus_data_in[2:0] : tac_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      irq_d       = 1'b0;
      reload_base = tima_q;

      case (state_q)
         S_IDLE: begin
            // A TIMA write on the same edge as a tick wins and drops the tick.
            if (commit_tima) begin
               tima_d = bus.bus_data_in;
            end else if (tick) begin
               if (tima_q == 8'hFF) begin
                  tima_d  = 8'h00;
                  state_d = S_PENDING;
                  cnt_d   = 2'd3;
               end else begin
                  tima_d = tima_q + 8'd1;
               end
            end
         end

         S_PENDING: begin
            cnt_d = cnt_q - 2'd1;
            // A TIMA write here cancels the pending reload and interrupt.
            if (commit_tima) begin
               tima_d  = bus.bus_data_in;
               state_d = S_IDLE;
            end else if (cnt_q == 2'd0) begin
               // tma_d so that a TMA write on this very edge is reloaded.
               tima_d  = tma_d;
               irq_d   = 1'b1;
               state_d = S_RELOAD;
               cnt_d   = 2'd3;
            end else if (tick) begin
               tima_d = tima_q + 8'd1;
            end
         end

         S_RELOAD: begin
            cnt_d = cnt_q - 2'd1;
            // TIMA writes are ignored; a TMA write is mirrored into TIMA.
            if (commit_tma) begin
               reload_base = bus.bus_data_in;
            end
            tima_d = reload_base;
            if (cnt_q == 2'd0) begin
               state_d = S_IDLE;
            end
            if (tick) begin
               if (reload_base == 8'hFF) begin
                  tima_d  = 8'h00;
                  state_d = S_PENDING;
                  cnt_d   = 2'd3;
               end else begin
                  tima_d = reload_base + 8'd1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         div_q          <= 16'h0000;
         tima_q         <= 8'h00;
         tma_q          <= 8'h00;
         tac_q          <= 3'b000;
         timer_signal_q <= 1'b0;
         state_q        <= S_IDLE;
         cnt_q          <= 2'd0;
         irq_q          <= 1'b0;
      end else begin
         div_q          <= div_d;
         tima_q         <= tima_d;
         tma_q          <= tma_d;
         tac_q          <= tac_d;
         timer_signal_q <= timer_signal;
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         irq_q          <= irq_d;
      end
   end

endmodule

// File: tb/tb_cpu_timer.sv
// -----------------------------------------------------------------------------
// tb_cpu_timer
//   Drives CPU-style bus cycles into cpu_timer. A timestamp-based reference
//   model predicts register contents and the interrupt line; expected read
//   data and per-clock interrupt values are queued at issue time and a
//   separate monitor pops and compares them on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_cpu_timer;

   localparam logic [15:0] BASE     = 16'hFF04;
   localparam logic [15:0] A_DIV    = BASE;
   localparam logic [15:0] A_TIMA   = BASE + 16'd1;
   localparam logic [15:0] A_TMA    = BASE + 16'd2;
   localparam logic [15:0] A_TAC    = BASE + 16'd3;

   logic clk = 1'b0;
   logic reset;
   logic irq_timer;

   always #5 clk = ~clk;

   cpu_timer_if bus_if ();

   cpu_timer #(.BASE_ADDR(BASE)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus_if),
      .irq_timer (irq_timer)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [15:0] addr;
      logic        sel;
      logic [7:0]  data;
   } rd_exp_t;

   rd_exp_t rd_q[$];
   bit      irq_q[$];
   int      n_tests   = 0;
   int      n_fail    = 0;
   int      irq_seen  = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_tests++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model. Time is counted in clock edges; an overflow at edge n
   // schedules the reload at edge n+4 and a reload window up to edge n+8.
   // ---------------------------------------------------------------------------
   int     m_div, m_tima, m_tma, m_tac;
   bit     m_prev_sig, m_irq;
   longint m_cyc         = 0;
   longint m_reload_edge = -1;

   function automatic int tap_of(int sel);
      case (sel)
         0:       return 9;
         1:       return 3;
         2:       return 5;
         default: return 7;
      endcase
   endfunction

   function automatic void model_step(bit rst, bit en, bit wr, int addr, int data, int tc);
      longint e       = m_cyc + 1;
      int     off     = addr - int'(BASE);
      bit     wcommit = en && wr && (tc == 3) && (off >= 0) && (off <= 3);
      bit     w_div   = wcommit && (off == 0);
      bit     w_tima  = wcommit && (off == 1);
      bit     w_tma   = wcommit && (off == 2);
      bit     w_tac   = wcommit && (off == 3);
      bit     sig     = ((m_tac & 4) != 0) && (((m_div >> tap_of(m_tac % 4)) & 1) == 1);
      bit     tick    = m_prev_sig && !sig;
      bit     in_pend = (m_reload_edge >= 0) && (e >= m_reload_edge - 3) && (e <= m_reload_edge);
      bit     in_rel  = (m_reload_edge >= 0) && (e > m_reload_edge) && (e <= m_reload_edge + 4);
      int     new_tma = w_tma ? data : m_tma;
      m_cyc = e;
      m_irq = 0;
      if (rst) begin
         m_div = 0; m_tima = 0; m_tma = 0; m_tac = 0;
         m_prev_sig = 0; m_reload_edge = -1;
         return;
      end
      if (in_pend) begin
         if (w_tima) begin
            m_tima = data;
            m_reload_edge = -1;
         end else if (e == m_reload_edge) begin
            m_tima = new_tma;
            m_irq  = 1;
         end else if (tick) begin
            m_tima = (m_tima + 1) % 256;
         end
      end else begin
         if (in_rel) m_tima = w_tma ? data : m_tima;
         else if (w_tima) m_tima = data;
         if (tick && !(w_tima && !in_rel)) begin
            if (m_tima == 255) begin
               m_tima = 0;
               m_reload_edge = e + 4;
            end else begin
               m_tima = m_tima + 1;
            end
         end
      end
      m_div      = w_div ? 0 : (m_div + 1) % 65536;
      m_tma      = new_tma;
      m_tac      = w_tac ? (data & 7) : m_tac;
      m_prev_sig = sig;
   endfunction

   function automatic rd_exp_t model_read(logic [15:0] addr);
      rd_exp_t r;
      int off = int'(addr) - int'(BASE);
      r.addr = addr;
      r.sel  = 1'b1;
      case (off)
         0:       r.data = 8'(m_div / 256);
         1:       r.data = 8'(m_tima);
         2:       r.data = 8'(m_tma);
         3:       r.data = 8'(248 + m_tac);
         default: begin r.sel = 1'b0; r.data = 8'hFF; end
      endcase
      return r;
   endfunction

   function automatic bit m_pending_entered();
      return (m_reload_edge >= 0) && (m_cyc == m_reload_edge - 4);
   endfunction

   function automatic bit m_reload_entered();
      return (m_reload_edge >= 0) && (m_cyc == m_reload_edge);
   endfunction

   // ---------------------------------------------------------------------------
   // Stimulus helpers. Inputs change 1 ns after the rising edge.
   // ---------------------------------------------------------------------------
   int tc_cnt = 0;

   task automatic drive_clk(input bit rst, input bit en, input bit wr,
                            input logic [15:0] addr, input logic [7:0] data);
      reset              = rst;
      bus_if.t_cycle     = 2'(tc_cnt % 4);
      bus_if.bus_enable  = en;
      bus_if.bus_write   = wr;
      bus_if.bus_addr    = addr;
      bus_if.bus_data_in = data;
      if (en && !wr) rd_q.push_back(model_read(addr));
      @(posedge clk);
      #1;
      model_step(rst, en, wr, int'(addr), int'(data), tc_cnt % 4);
      irq_q.push_back(m_irq);
      tc_cnt++;
   endtask

   task automatic idle(input int n);
      repeat (n) drive_clk(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
   endtask

   task automatic align();
      while (tc_cnt % 4 != 0) idle(1);
   endtask

   task automatic wr_reg(input logic [15:0] addr, input logic [7:0] data);
      align();
      repeat (4) drive_clk(1'b0, 1'b1, 1'b1, addr, data);
   endtask

   task automatic rd_reg(input logic [15:0] addr, input int mcycles);
      align();
      repeat (4 * mcycles) drive_clk(1'b0, 1'b1, 1'b0, addr, 8'h00);
   endtask

   // Write from the current clock through the next commit edge.
   task automatic write_now(input logic [15:0] addr, input logic [7:0] data);
      bit last;
      last = 1'b0;
      while (!last) begin
         last = (tc_cnt % 4 == 3);
         drive_clk(1'b0, 1'b1, 1'b1, addr, data);
      end
   endtask

   task automatic do_reset();
      repeat (2) drive_clk(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
   endtask

   task automatic setup_overflow();
      do_reset();
      wr_reg(A_TMA, 8'hF0);
      wr_reg(A_TIMA, 8'hFF);
      wr_reg(A_TAC, 8'h05);
   endtask

   // ---------------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------------
   initial begin
      rd_exp_t exp_rd;
      bit      exp_irq;
      forever begin
         @(negedge clk);
         if (irq_q.size() > 0) begin
            exp_irq = irq_q.pop_front();
            check("irq_timer", irq_timer, exp_irq);
         end
         if (irq_timer === 1'b1) irq_seen++;
         if (bus_if.bus_enable === 1'b1 && bus_if.bus_write === 1'b0 && rd_q.size() > 0) begin
            exp_rd = rd_q.pop_front();
            check($sformatf("sel@%h", exp_rd.addr), bus_if.bus_selected, exp_rd.sel);
            check($sformatf("rd@%h", exp_rd.addr), bus_if.bus_data_out, exp_rd.data);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin
      int          s0;
      int          r;
      int          k;
      logic [15:0] a;
      logic [7:0]  d;

      // 1. Reset state, then counting with tap bit 3 and DIV crossing 256.
      do_reset();
      rd_reg(A_DIV, 1);
      rd_reg(A_TIMA, 1);
      rd_reg(A_TMA, 1);
      rd_reg(A_TAC, 1);
      wr_reg(A_TAC, 8'h05);
      rd_reg(A_TIMA, 20);
      rd_reg(A_DIV, 70);

      // 2. Overflow, four clocks of 00, reload to F0 with a single irq.
      setup_overflow();
      s0 = irq_seen;
      rd_reg(A_TIMA, 40);
      check("t2_irq_count", irq_seen - s0, 1);

      // 3. TIMA write during Pending cancels the reload.
      setup_overflow();
      s0 = irq_seen;
      for (k = 0; k < 400 && !m_pending_entered(); k++) idle(1);
      check("t3_reached_pending", m_pending_entered(), 1);
      write_now(A_TIMA, 8'h42);
      rd_reg(A_TIMA, 3);
      check("t3_irq_count", irq_seen - s0, 0);

      // 4. TIMA write during Reload is ignored; TMA write lands in TIMA.
      setup_overflow();
      for (k = 0; k < 400 && !m_reload_entered(); k++) idle(1);
      check("t4a_reached_reload", m_reload_entered(), 1);
      write_now(A_TIMA, 8'h11);
      rd_reg(A_TIMA, 3);
      setup_overflow();
      for (k = 0; k < 400 && !m_reload_entered(); k++) idle(1);
      check("t4b_reached_reload", m_reload_entered(), 1);
      write_now(A_TMA, 8'h33);
      rd_reg(A_TIMA, 3);
      rd_reg(A_TMA, 1);

      // 5. DIV reset while the tap bit is high gives an extra tick; then a
      //    TAC rewrite at a similar phase.
      do_reset();
      wr_reg(A_TAC, 8'h05);
      for (k = 0; k < 64 && !(((m_div + 3) >> 3) % 2 == 1); k += 4) idle(4);
      check("t5_tap_high", ((m_div + 3) >> 3) % 2, 1);
      wr_reg(A_DIV, 8'h5A);
      rd_reg(A_DIV, 1);
      rd_reg(A_TIMA, 2);
      for (k = 0; k < 64 && !(((m_div + 3) >> 3) % 2 == 1); k += 4) idle(4);
      wr_reg(A_TAC, 8'h01);
      rd_reg(A_TIMA, 2);
      rd_reg(A_TAC, 1);

      // 6. Decode edges and reset in the middle of Pending.
      wr_reg(A_TAC, 8'h05);
      rd_reg(A_TAC, 1);
      rd_reg(16'hFF03, 1);
      rd_reg(16'hFF08, 1);
      setup_overflow();
      s0 = irq_seen;
      for (k = 0; k < 400 && !m_pending_entered(); k++) idle(1);
      check("t6_reached_pending", m_pending_entered(), 1);
      idle(1);
      do_reset();
      idle(8);
      rd_reg(A_TIMA, 1);
      rd_reg(A_TAC, 1);
      check("t6_irq_count", irq_seen - s0, 0);

      // Randomized traffic.
      do_reset();
      wr_reg(A_TAC, 8'h05);
      for (int i = 0; i < 500; i++) begin
         r = $urandom_range(0, 99);
         a = BASE + 16'($urandom_range(0, 3));
         d = 8'($urandom);
         if (r < 2) begin
            do_reset();
         end else if (r < 25) begin
            idle($urandom_range(1, 8));
         end else if (r < 60) begin
            if ($urandom_range(0, 9) == 0) a = ($urandom_range(0, 1) == 0) ? 16'hFF03 : 16'hFF08;
            rd_reg(a, $urandom_range(1, 3));
         end else begin
            if (a == A_TIMA && $urandom_range(0, 3) != 0) d = 8'($urandom_range(250, 255));
            if (a == A_TAC) d = {d[7:3], ($urandom_range(0, 9) < 8), ($urandom_range(0, 2) == 0) ? d[1:0] : 2'b01};
            if (a == A_DIV && $urandom_range(0, 2) != 0) a = A_TMA;
            wr_reg(a, d);
         end
      end

      idle(4);
      @(negedge clk);
      #1;
      check("rd_queue_drained", rd_q.size(), 0);
      check("irq_queue_drained", irq_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
